// File: rtl/crypt_pkg.sv
// rtl/crypt_pkg.sv - shared byte/state types, FSM encoding and inverse S-box table
package crypt_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [3:0][3:0] state_t;

    typedef enum logic [1:0] {IDLE, SUB, DONE} fsm_t;

    // Index 0 sits in the leftmost byte of the literal.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

endpackage

// File: rtl/reverse_substitution_if.sv
// rtl/reverse_substitution_if.sv - valid/ready state bus into and out of reverse_substitution
interface reverse_substitution_if;
    import crypt_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t state_in;
    logic   out_valid;
    logic   out_ready;
    state_t state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );

endinterface

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational inverse AES S-box lookup
module inv_sbox
    import crypt_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/reverse_substitution.sv
// rtl/reverse_substitution.sv - inverse ShiftRows at capture, then LANES-wide inverse SubBytes over 16/LANES cycles
// Optional synchronous flush input enabled by REVERSE_SUBST_FLUSH_EN.
module reverse_substitution
    import crypt_pkg::*;
#(
    parameter int LANES = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef REVERSE_SUBST_FLUSH_EN
    input logic flush,
`endif
    reverse_substitution_if.slave bus
);

    localparam int N  = 16 / LANES;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    fsm_t          state_q, state_d;
    state_t        buf_q, buf_d;
    state_t        out_q, out_d;
    state_t        shifted;
    logic [KW-1:0] k_q, k_d;

    logic [3:0] lane_idx [LANES];
    byte_t      lane_in  [LANES];
    byte_t      lane_out [LANES];

    // Row r rotates right by r: column c takes row r from column (c - r) mod 4.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[2'(c)][2'(r)] = bus.state_in[2'(c - r)][2'(r)];
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(k_q) * LANES + l);
            lane_in[l]  = buf_q[lane_idx[l][3:2]][lane_idx[l][1:0]];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .in_byte  (lane_in[l]),
            .out_byte (lane_out[l])
        );
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        out_d   = out_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = shifted;
                    k_d     = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int l = 0; l < LANES; l++) begin
                    buf_d[lane_idx[l][3:2]][lane_idx[l][1:0]] = lane_out[l];
                end
                if (k_q == K_LAST) begin
                    out_d   = buf_d;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef REVERSE_SUBST_FLUSH_EN
        if (flush) begin
            state_d = IDLE;
            buf_d   = buf_q;
            k_d     = '0;
            out_d   = out_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            out_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            out_q   <= out_d;
            k_q     <= k_d;
        end
    end

    // Gated by rst_n so upstream never sees ready while the block is held in reset.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.state_out = out_q;

endmodule

// File: tb/tb_reverse_substitution.sv
// tb/tb_reverse_substitution.sv - directed scoreboard bench for reverse_substitution (LANES=4)
module tb_reverse_substitution;
    import crypt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
`ifdef REVERSE_SUBST_FLUSH_EN
    logic flush = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    state_t sb [$];

    reverse_substitution_if bus ();

    reverse_substitution #(.LANES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef REVERSE_SUBST_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic state_t fill(input byte_t b);
        state_t s;
        for (int i = 0; i < 16; i++) s[i/4][i%4] = b;
        return s;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input state_t obs, input state_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capture edge.
    task automatic send(input state_t s, input state_t exp, input bit push);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.state_in = s;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk1("send_ready_timeout", bus.in_ready, 1'b1);
        @(posedge clk);
        if (push) sb.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at a negedge; waits for out_valid, checks against the scoreboard, consumes.
    task automatic receive(input string tag, output int lat, output int when);
        int n = 0;
        state_t e;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat  = n;
        when = cyc;
        chk1({tag, "_valid"}, bus.out_valid, 1'b1);
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chks({tag, "_data"}, bus.state_out, e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        state_t s;
        state_t e;
        int lat, t1, t2;
        bus.in_valid  = 1'b0;
        bus.state_in  = '0;
        bus.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chks("rst_state_out", bus.state_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);

        // All 0x63 -> all 0x00 after N=4 cycles
        send(fill(8'h63), fill(8'h00), 1'b1);
        receive("s63", lat, t1);
        chk1("s63_latency", lat == 4, 1'b1);
        chk1("s63_idle_ready", bus.in_ready, 1'b1);

        send(fill(8'h00), fill(8'h52), 1'b1);
        receive("s00", lat, t1);
        chk1("s00_latency", lat == 4, 1'b1);
        send(fill(8'h16), fill(8'hff), 1'b1);
        receive("s16", lat, t1);

        // Reset in the middle of SUB discards the work in flight
        send(fill(8'h00), fill(8'h52), 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("midrst_out_valid", bus.out_valid, 1'b0);
        chks("midrst_state_out", bus.state_out, '0);
        chk1("midrst_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("midrst_after_in_ready", bus.in_ready, 1'b1);
        chk1("midrst_after_out_valid", bus.out_valid, 1'b0);

        // Inverse ShiftRows: in[0][1] lands in out[1][1]
        s = fill(8'h63);
        s[0][1] = 8'h7c;
        e = fill(8'h00);
        e[1][1] = 8'h01;
        send(s, e, 1'b1);
        receive("shift", lat, t1);

        // Backpressure holds state_out and in_ready low
        bus.out_ready = 1'b0;
        send(fill(8'h00), fill(8'h52), 1'b1);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chks("bp_data", bus.state_out, e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chks("bp_stable", bus.state_out, fill(8'h52));
            chk1("bp_in_ready", bus.in_ready, 1'b0);
            chk1("bp_out_valid", bus.out_valid, 1'b1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_out_valid", bus.out_valid, 1'b0);
        chk1("bp_release_in_ready", bus.in_ready, 1'b1);
        chks("bp_hold_after", bus.state_out, fill(8'h52));

        // Back-to-back states: results N+2 cycles apart
        fork
            begin
                send(fill(8'h00), fill(8'h52), 1'b1);
                send(fill(8'h63), fill(8'h00), 1'b1);
            end
            begin
                receive("b2b_a", lat, t1);
                receive("b2b_b", lat, t2);
            end
        join
        chk1("b2b_spacing", (t2 - t1) == 6, 1'b1);

`ifdef REVERSE_SUBST_FLUSH_EN
        // Flush at k=2 drops the state; the next one processes normally
        send(fill(8'h16), fill(8'hff), 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk1("flush_no_valid", bus.out_valid, 1'b0);
            @(negedge clk);
        end
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.state_in = fill(8'h16);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk1("flush_wins_idle", bus.in_ready, 1'b1);
        send(fill(8'h63), fill(8'h00), 1'b1);
        receive("flush_next", lat, t1);
        chk1("flush_next_latency", lat == 4, 1'b1);
`endif

        chk1("sb_empty", sb.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
